// File: rtl/icache_refill_arb.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_arb
// Description : Arbitrates I$ miss / prefetch refills onto one read channel
//               and routes return beats back by rd_id_i[0].
//               Define ICACHE_REFILL_ARB_RR_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_arb #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned BlenWidth = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdBase    = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [1:0]                    req_i,
    output logic [1:0]                    gnt_o,
    input  logic [1:0][AddrWidth-1:0]     addr_i,
    input  logic [1:0][BlenWidth-1:0]     blen_i,
    output logic                          rd_req_o,
    input  logic                          rd_gnt_i,
    output logic [AddrWidth-1:0]          rd_addr_o,
    output logic [BlenWidth-1:0]          rd_blen_o,
    output logic [IdWidth-1:0]            rd_id_o,
    input  logic                          rd_valid_i,
    input  logic                          rd_last_i,
    input  logic [DataWidth-1:0]          rd_data_i,
    input  logic [IdWidth-1:0]            rd_id_i,
    output logic [1:0]                    valid_o,
    output logic [1:0]                    last_o,
    output logic [DataWidth-1:0]          data_o,
    output logic [1:0]                    busy_o,
    output logic                          err_o
);

    localparam logic [IdWidth-2:0] c_id_base = IdBase[IdWidth-2:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                       r_state;
    state_e                       w_state_nxt;
    logic [AddrWidth-1:0]         r_hold_addr;
    logic [BlenWidth-1:0]         r_hold_blen;
    logic                         r_hold_idx;
    logic [1:0]                   r_busy;
    logic [1:0][BlenWidth-1:0]    r_cnt;
    logic [1:0][BlenWidth-1:0]    r_blen;
    logic                         r_err;
    logic [1:0]                   w_elig;
    logic                         w_pick;
    logic                         w_sel;
    logic                         w_accept;
    logic [1:0]                   w_bad;
    logic                         w_unused_id;

    assign w_elig = req_i & ~r_busy;

`ifdef ICACHE_REFILL_ARB_RR_EN
    logic r_ptr;

    assign w_pick = (&w_elig) ? r_ptr : ~w_elig[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_sel;
        end
    end
`else
    assign w_pick = ~w_elig[0];
`endif

    // rd_req_o is combinational in IDLE, so it is also qualified by reset
    always_comb begin
        w_state_nxt = r_state;
        rd_req_o    = 1'b0;
        rd_addr_o   = '0;
        rd_blen_o   = '0;
        w_sel       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|w_elig) && rst_ni) begin
                    rd_req_o  = 1'b1;
                    w_sel     = w_pick;
                    rd_addr_o = addr_i[w_pick];
                    rd_blen_o = blen_i[w_pick];
                    if (rd_gnt_i) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                rd_req_o  = 1'b1;
                w_sel     = r_hold_idx;
                rd_addr_o = r_hold_addr;
                rd_blen_o = r_hold_blen;
                if (rd_gnt_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        rd_id_o = rd_req_o ? {c_id_base, w_sel} : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_hold_addr <= '0;
            r_hold_blen <= '0;
            r_hold_idx  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_hold_addr <= rd_addr_o;
                r_hold_blen <= rd_blen_o;
                r_hold_idx  <= w_sel;
            end
        end
    end

    assign gnt_o   = {w_accept & w_sel, w_accept & ~w_sel};
    assign valid_o = {rd_valid_i & rd_id_i[0], rd_valid_i & ~rd_id_i[0]};
    assign last_o  = valid_o & {2{rd_last_i}};
    assign data_o  = rd_data_i;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

    // Upper ID bits carry IdBase only; ownership lives in bit 0
    assign w_unused_id = ^rd_id_i[IdWidth-1:1];

    always_comb begin
        w_bad = '0;
        for (int k = 0; k < 2; k++) begin
            w_bad[k] = valid_o[k] & (~r_busy[k]
                     | ( rd_last_i & (r_cnt[k] != r_blen[k]))
                     | (~rd_last_i & (r_cnt[k] == r_blen[k])));
        end
    end

    // A grant overrides any same-cycle beat bookkeeping for that requester
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_blen <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= r_err | (|w_bad);
            for (int k = 0; k < 2; k++) begin
                if (valid_o[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
                if (last_o[k]) begin
                    r_busy[k] <= 1'b0;
                end
                if (gnt_o[k]) begin
                    r_busy[k] <= 1'b1;
                    r_cnt[k]  <= '0;
                    r_blen[k] <= rd_blen_o;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_arb
// Description : Self-checking bench: directed table, corner sequences and
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_arb;

    localparam int AW  = 64;
    localparam int IW  = 4;
    localparam int BW  = 2;
    localparam int DW  = 64;
    localparam int IDB = 0;
    localparam int NB  = 1 << BW;
`ifdef ICACHE_REFILL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [1:0]             req_i = '0;
    logic [1:0]             gnt_o;
    logic [1:0][AW-1:0]     addr_i = '0;
    logic [1:0][BW-1:0]     blen_i = '0;
    logic                   rd_req_o;
    logic                   rd_gnt_i = 1'b0;
    logic [AW-1:0]          rd_addr_o;
    logic [BW-1:0]          rd_blen_o;
    logic [IW-1:0]          rd_id_o;
    logic                   rd_valid_i = 1'b0;
    logic                   rd_last_i = 1'b0;
    logic [DW-1:0]          rd_data_i = '0;
    logic [IW-1:0]          rd_id_i = '0;
    logic [1:0]             valid_o;
    logic [1:0]             last_o;
    logic [DW-1:0]          data_o;
    logic [1:0]             busy_o;
    logic                   err_o;

    icache_refill_arb #(
        .AddrWidth (AW),
        .IdWidth   (IW),
        .BlenWidth (BW),
        .DataWidth (DW),
        .IdBase    (IDB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .blen_i     (blen_i),
        .rd_req_o   (rd_req_o),
        .rd_gnt_i   (rd_gnt_i),
        .rd_addr_o  (rd_addr_o),
        .rd_blen_o  (rd_blen_o),
        .rd_id_o    (rd_id_o),
        .rd_valid_i (rd_valid_i),
        .rd_last_i  (rd_last_i),
        .rd_data_i  (rd_data_i),
        .rd_id_i    (rd_id_i),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one pending (unaccepted) request plus per-requester
    // outstanding burst bookkeeping.
    bit          m_pend;
    int          m_pidx;
    logic [63:0] m_paddr;
    int          m_pblen;
    bit          m_busy[2];
    int          m_beats[2];
    int          m_blen[2];
    bit          m_err;
    int          m_ptr;
    int          m_gidx;
    logic [1:0]  s_gnt, s_valid, s_last;

    task automatic model_reset();
        m_pend = 0; m_pidx = 0; m_paddr = 0; m_pblen = 0;
        m_err = 0; m_ptr = 0; m_gidx = -1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_beats[k] = 0; m_blen[k] = 0;
        end
    endtask

    task automatic clear_inputs();
        req_i = '0; addr_i = '0; blen_i = '0; rd_gnt_i = 0;
        rd_valid_i = 0; rd_last_i = 0; rd_data_i = '0; rd_id_i = '0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic step();
        bit e0, e1, ereq, acc;
        int sel, eblen, k;
        logic [63:0] eaddr;
        #3;
        e0 = req_i[0] && !m_busy[0];
        e1 = req_i[1] && !m_busy[1];
        ereq = 0; sel = 0; eaddr = 0; eblen = 0;
        if (m_pend) begin
            ereq = 1; sel = m_pidx; eaddr = m_paddr; eblen = m_pblen;
        end else if (e0 || e1) begin
            ereq = 1;
            if (e0 && e1) sel = RR ? m_ptr : 0;
            else          sel = e0 ? 0 : 1;
            eaddr = addr_i[sel];
            eblen = int'(blen_i[sel]);
        end
        acc = ereq && rd_gnt_i;
        s_gnt = gnt_o; s_valid = valid_o; s_last = last_o;
        chk("rd_req",  rd_req_o,  ereq);
        chk("rd_addr", rd_addr_o, eaddr);
        chk("rd_blen", rd_blen_o, eblen);
        chk("rd_id",   rd_id_o,   ereq ? ((IDB << 1) | sel) : 0);
        chk("gnt",     gnt_o,     acc ? (1 << sel) : 0);
        chk("valid",   valid_o,   rd_valid_i ? (1 << rd_id_i[0]) : 0);
        chk("last",    last_o,    (rd_valid_i && rd_last_i) ? (1 << rd_id_i[0]) : 0);
        chk("data",    data_o,    rd_data_i);
        chk("busy",    busy_o,    {m_busy[1], m_busy[0]});
        chk("err",     err_o,     m_err);
        if (rd_valid_i) begin
            k = int'(rd_id_i[0]);
            if (!m_busy[k] || (rd_last_i && m_beats[k] != m_blen[k]) ||
                (!rd_last_i && m_beats[k] == m_blen[k]))
                m_err = 1;
            m_beats[k] = (m_beats[k] + 1) % NB;
            if (rd_last_i) m_busy[k] = 0;
        end
        m_gidx = -1;
        if (acc) begin
            m_busy[sel] = 1; m_beats[sel] = 0; m_blen[sel] = eblen;
            m_pend = 0; m_gidx = sel;
            if (RR) m_ptr = 1 - sel;
        end else if (ereq && !m_pend) begin
            m_pend = 1; m_pidx = sel; m_paddr = eaddr; m_pblen = eblen;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        req_i = 2'b11; addr_i[0] = 64'hdead; addr_i[1] = 64'hbeef; rd_gnt_i = 1;
        #3;
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_gnt",    gnt_o,    0);
        chk("rst_busy",   busy_o,   0);
        chk("rst_err",    err_o,    0);
        @(posedge clk);
        #1;
        clear_inputs();
        rst_ni = 1;
        model_reset();
    endtask

    task automatic beat(input int k, input bit last);
        clear_inputs();
        rd_valid_i = 1; rd_last_i = last; rd_id_i = IW'(k);
        rd_data_i = {$urandom, $urandom};
        step();
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [63:0] a0;
        logic [1:0]  b0;
        logic        gnt;
        logic        v;
        logic        l;
        logic [3:0]  id;
        logic        ereq;
        logic [63:0] eaddr;
        logic [3:0]  eid;
        logic [1:0]  egnt;
        logic [1:0]  evalid;
        logic [1:0]  elast;
        logic [1:0]  ebusy;
        logic        eerr;
    } vec_t;

    vec_t tbl[11];
    int   rem[2];

    initial begin
        // Single burst with same-cycle grant, then delayed grant with changing addr_i
        tbl[0]  = '{2'b01, 64'h1000, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 64'h1000, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{2'b00, 64'h0,    2'd0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 64'h0,    4'h0, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0};
        tbl[2]  = '{2'b00, 64'h0,    2'd0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 64'h0,    4'h0, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0};
        tbl[3]  = '{2'b00, 64'h0,    2'd0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 64'h0,    4'h0, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0};
        tbl[4]  = '{2'b00, 64'h0,    2'd0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 64'h0,    4'h0, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0};
        tbl[5]  = '{2'b00, 64'h0,    2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0,    4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[6]  = '{2'b01, 64'h1000, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 64'h1000, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{2'b01, 64'h2000, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 64'h1000, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{2'b01, 64'h3000, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 64'h1000, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{2'b01, 64'h4000, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 64'h1000, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[10] = '{2'b01, 64'h5000, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0,    4'h0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};

        clear_inputs();
        model_reset();
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            req_i = tbl[i].req; addr_i[0] = tbl[i].a0; blen_i[0] = tbl[i].b0;
            rd_gnt_i = tbl[i].gnt; rd_valid_i = tbl[i].v; rd_last_i = tbl[i].l;
            rd_id_i = tbl[i].id; rd_data_i = {$urandom, $urandom};
            #3;
            chk($sformatf("tbl%0d_rd_req", i),  rd_req_o,  tbl[i].ereq);
            chk($sformatf("tbl%0d_rd_addr", i), rd_addr_o, tbl[i].eaddr);
            chk($sformatf("tbl%0d_rd_id", i),   rd_id_o,   tbl[i].eid);
            chk($sformatf("tbl%0d_gnt", i),     gnt_o,     tbl[i].egnt);
            chk($sformatf("tbl%0d_valid", i),   valid_o,   tbl[i].evalid);
            chk($sformatf("tbl%0d_last", i),    last_o,    tbl[i].elast);
            chk($sformatf("tbl%0d_data", i),    data_o,    rd_data_i);
            chk($sformatf("tbl%0d_busy", i),    busy_o,    tbl[i].ebusy);
            chk($sformatf("tbl%0d_err", i),     err_o,     tbl[i].eerr);
            @(posedge clk);
            #1;
        end

        // Both requesting every time: arbitration order
        do_reset();
        for (int it = 0; it < 4; it++) begin
            clear_inputs();
            req_i = 2'b11; addr_i[0] = 64'h100 * (it + 1); addr_i[1] = 64'h8000 + it;
            rd_gnt_i = 1;
            step();
            chk("arb_order", s_gnt, RR ? (1 << (it % 2)) : 2'b01);
            beat(RR ? (it % 2) : 0, 1);
        end

        // Both outstanding, returns interleaved id0,id1,id1,id0
        do_reset();
        clear_inputs(); req_i = 2'b01; addr_i[0] = 64'hA0; blen_i[0] = 2'd1; rd_gnt_i = 1;
        step();
        clear_inputs(); req_i = 2'b10; addr_i[1] = 64'hB0; blen_i[1] = 2'd1; rd_gnt_i = 1;
        step();
        chk("both_busy", busy_o, 2'b11);
        beat(0, 0); chk("il_v0", s_valid, 2'b01); chk("il_l0", s_last, 2'b00);
        beat(1, 0); chk("il_v1", s_valid, 2'b10); chk("il_l1", s_last, 2'b00);
        beat(1, 1); chk("il_v2", s_valid, 2'b10); chk("il_l2", s_last, 2'b10);
        beat(0, 1); chk("il_v3", s_valid, 2'b01); chk("il_l3", s_last, 2'b01);
        chk("il_err", err_o, 0);
        chk("il_idle", busy_o, 2'b00);

        // Stray beat for an idle requester, sticky until reset
        do_reset();
        beat(1, 0);
        chk("stray_err", err_o, 1);
        clear_inputs();
        for (int i = 0; i < 3; i++) step();
        chk("stray_err_sticky", err_o, 1);
        do_reset();
        chk("err_cleared", err_o, 0);

        // Early last: blen 3 terminated after 2 beats
        clear_inputs(); req_i = 2'b01; addr_i[0] = 64'h1000; blen_i[0] = 2'd3; rd_gnt_i = 1;
        step();
        beat(0, 0);
        beat(0, 1);
        chk("short_burst_err", err_o, 1);
        clear_inputs();
        step();
        chk("short_burst_sticky", err_o, 1);

        // Reset with a request held pending
        do_reset();
        clear_inputs(); req_i = 2'b10; addr_i[1] = 64'h77;
        step();
        do_reset();
        clear_inputs();
        step();
        chk("hold_dropped", rd_req_o, 0);

        // Randomized traffic with a well-behaved return shim and rare bogus beats
        do_reset();
        rem[0] = 0; rem[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int k;
            if (cyc % 400 == 399) begin
                do_reset();
                rem[0] = 0; rem[1] = 0;
            end
            clear_inputs();
            req_i = 2'($urandom);
            addr_i[0] = {$urandom, $urandom};
            addr_i[1] = {$urandom, $urandom};
            blen_i[0] = 2'($urandom);
            blen_i[1] = 2'($urandom);
            rd_gnt_i = 1'($urandom);
            rd_data_i = {$urandom, $urandom};
            if ($urandom % 250 == 0) begin
                rd_valid_i = 1; rd_last_i = 1'($urandom); rd_id_i = 4'($urandom);
            end else if ($urandom % 3 != 0 && (rem[0] > 0 || rem[1] > 0)) begin
                k = $urandom % 2;
                if (rem[k] == 0) k = 1 - k;
                rd_valid_i = 1;
                rd_last_i = (rem[k] == 1);
                rd_id_i = {3'($urandom), 1'(k)};
                rem[k]--;
            end
            step();
            if (m_gidx >= 0) rem[m_gidx] = m_blen[m_gidx] + 1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_refill_arb.md
ICACHE_REFILL_ARB -- requirements
Module: icache_refill_arb

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, request address width.
REQ-002 SHALL have parameter IdWidth, default 4, downstream transaction ID width (>=2).
REQ-003 SHALL have parameter BlenWidth, default 2, burst-length field width (beats-1).
REQ-004 SHALL have parameter DataWidth, default 64, return data width.
REQ-005 SHALL have parameter IdBase, default 0, upper ID bits driven on rd_id_o[IdWidth-1:1].
REQ-006 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-007 SHALL have ports: req_i in 2 per-requester read request (0=I$ miss, 1=prefetch); gnt_o out 2 per-requester grant pulse; addr_i in 2xAddrWidth; blen_i in 2xBlenWidth.
REQ-008 SHALL have ports: rd_req_o out 1; rd_gnt_i in 1; rd_addr_o out AddrWidth; rd_blen_o out BlenWidth; rd_id_o out IdWidth (toward axi read shim).
REQ-009 SHALL have ports: rd_valid_i in 1; rd_last_i in 1; rd_data_i in DataWidth; rd_id_i in IdWidth (return beats from shim).
REQ-010 SHALL have ports: valid_o out 2; last_o out 2; data_o out DataWidth (routed return); busy_o out 2 (outstanding flags); err_o out 1 sticky protocol error.

Function
REQ-011 SHALL implement FSM IDLE/HOLD: IDLE selects an eligible requester; HOLD keeps rd_req_o, rd_addr_o, rd_blen_o, rd_id_o stable until rd_gnt_i.
REQ-012 SHALL treat requester i eligible when req_i[i]=1 and busy_o[i]=0 (registered value).
REQ-013 SHALL assert rd_req_o combinationally in IDLE the same cycle an eligible request exists; if rd_gnt_i also high, grant completes that cycle and FSM stays IDLE, else go to HOLD.
REQ-014 SHALL capture addr/blen/index of the selected requester into a hold register on entering HOLD; requester inputs ignored while in HOLD.
REQ-015 SHALL pulse gnt_o[i] for exactly one cycle when rd_gnt_i accepts requester i's transaction; set busy_o[i] next cycle.
REQ-016 SHALL drive rd_id_o = {IdBase, i}; return ownership decoded solely from rd_id_i[0].
REQ-017 SHALL route each return beat: valid_o[k]=rd_valid_i & (rd_id_i[0]==k); last_o[k]=valid_o[k]&rd_last_i; data_o=rd_data_i; zero added latency.
REQ-018 SHALL keep one beat counter per requester (BlenWidth bits), cleared on grant, incremented per routed beat.
REQ-019 SHALL clear busy_o[k] on a last beat for k; requester k becomes eligible the following cycle.
REQ-020 SHALL set err_o when a beat arrives for k with busy_o[k]=0, or last arrives with counter != captured blen, or non-last beat arrives with counter == blen; err_o holds until reset.
REQ-021 SHALL permit both requesters outstanding simultaneously and interleaved returns.
REQ-022 SHALL, when no eligible request in IDLE, drive rd_req_o=0 and rd_addr_o/rd_blen_o/rd_id_o = 0.

Reset
REQ-023 SHALL, on rst_ni low, asynchronously force FSM=IDLE, busy_o=0, gnt_o=0, counters=0, err_o=0, priority pointer=0, rd_req_o=0.
REQ-024 SHALL, on reset mid-transaction, drop any HOLD request and discard tracking; later beats for stale IDs set err_o.

Configuration
REQ-025 SHALL honour macro ICACHE_REFILL_ARB_RR_EN: defined -> round-robin, pointer moves to other requester after each grant; both eligible -> pointer requester wins.
REQ-026 SHALL, without ICACHE_REFILL_ARB_RR_EN, use fixed priority: requester 0 always wins when both eligible; pointer logic absent.

Verification
REQ-027 SHALL cover: req_i=01, addr 0x1000, blen 3, rd_gnt_i same cycle -> gnt_o[0] pulse, rd_id_o=0x0, 4 beats with id 0 -> valid_o[0] x4, last_o[0] on 4th, busy_o[0] clears, err_o=0.
REQ-028 SHALL cover: req_i=01, rd_gnt_i delayed 3 cycles, addr_i changed meanwhile -> rd_addr_o stable 0x1000 all 4 cycles, single gnt_o[0].
REQ-029 SHALL cover: req_i=11 repeated with RR_EN -> grants alternate 0,1,0,1; without macro -> requester 0 granted whenever eligible.
REQ-030 SHALL cover: both outstanding, beats interleaved id0,id1,id1,id0 -> correct per-requester valid_o/last_o, err_o=0.
REQ-031 SHALL cover: beat with rd_id_i[0]=1 while busy_o[1]=0, and last after 2 beats with blen 3 -> err_o=1 and stays 1 until rst_ni low.
